// File: rtl/wishbone_master_pkg.sv
// Shared definitions for the Wishbone classic initiator.
//   wb_state_e      : controller states (IDLE / BUS / BACKOFF / RESP)
//   WB_ST_*         : completion status codes reported on rsp_status
//   wb_term_status  : maps the terminations seen on the closing edge of a
//                     bus attempt onto a completion status code
package wb_master_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUS     = 2'd1,
    BACKOFF = 2'd2,
    RESP    = 2'd3
  } wb_state_e;

  localparam logic [1:0] WB_ST_OK  = 2'd0;
  localparam logic [1:0] WB_ST_ERR = 2'd1;
  localparam logic [1:0] WB_ST_RTY = 2'd2;
  localparam logic [1:0] WB_ST_TMO = 2'd3;

  // ACK beats ERR beats RTY when a slave raises several at once. With no
  // termination at all the only way the attempt can close is the timeout.
  function automatic logic [1:0] wb_term_status(input logic ack,
                                                input logic err,
                                                input logic rty);
    if (ack)      return WB_ST_OK;
    else if (err) return WB_ST_ERR;
    else if (rty) return WB_ST_RTY;
    else          return WB_ST_TMO;
  endfunction

endpackage

// File: rtl/wishbone_master_if.sv
// Wishbone B4 classic bus bundle between one initiator and one target.
//   ADR_O, DAT_O, SEL_O, WE_O   : address, write data, byte selects, direction
//   TGD_O, TGA_O, TGC_O         : data / address / cycle tags
//   CYC_O, STB_O, LOCK_O        : cycle, strobe, bus lock
//   DAT_I                       : read data from the target
//   ACK_I, ERR_I, RTY_I         : target terminations
// The master modport drives the *_O signals, the slave modport the *_I ones.
interface wishbone_master_if #(
  parameter int WB_ADDR_W = 32,
  parameter int WB_DATA_W = 32,
  parameter int WB_TGD_W  = 8,
  parameter int WB_TGA_W  = 2,
  parameter int WB_TGC_W  = 4
);

  logic [WB_ADDR_W-1:0]   ADR_O;
  logic [WB_DATA_W-1:0]   DAT_O;
  logic [WB_DATA_W/8-1:0] SEL_O;
  logic                   WE_O;
  logic [WB_TGD_W-1:0]    TGD_O;
  logic [WB_TGA_W-1:0]    TGA_O;
  logic [WB_TGC_W-1:0]    TGC_O;
  logic                   CYC_O;
  logic                   STB_O;
  logic                   LOCK_O;
  logic [WB_DATA_W-1:0]   DAT_I;
  logic                   ACK_I;
  logic                   ERR_I;
  logic                   RTY_I;

  modport master (
    output ADR_O, DAT_O, SEL_O, WE_O, TGD_O, TGA_O, TGC_O,
    output CYC_O, STB_O, LOCK_O,
    input  DAT_I, ACK_I, ERR_I, RTY_I
  );

  modport slave (
    input  ADR_O, DAT_O, SEL_O, WE_O, TGD_O, TGA_O, TGC_O,
    input  CYC_O, STB_O, LOCK_O,
    output DAT_I, ACK_I, ERR_I, RTY_I
  );

endinterface

// File: rtl/wishbone_master.sv
// Wishbone classic initiator: converts a valid/ready command into one
// Wishbone read or write cycle and reports completion as a one-cycle
// response pulse. RTY terminations are re-issued (after a one-cycle gap with
// CYC_O low) up to MAX_RETRY times; an attempt that sees no termination for
// TIMEOUT strobe cycles is abandoned with a TIMEOUT status.
//
// Ports
//   CLK_I, RST_I        : clock, synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake
//   cmd_we, cmd_adr, cmd_dat, cmd_sel, cmd_lock, cmd_tgd/tga/tgc
//                       : command fields, registered at the handshake
//   rsp_valid           : one-cycle completion pulse
//   rsp_dat, rsp_status : read data / status (0 OK, 1 ERR, 2 RTY, 3 TIMEOUT),
//                         zero whenever rsp_valid is low
//   wb                  : Wishbone master bundle
module wishbone_master
  import wb_master_pkg::*;
#(
  parameter int WB_ADDR_W = 32,
  parameter int WB_DATA_W = 32,
  parameter int WB_TGD_W  = 8,
  parameter int WB_TGA_W  = 2,
  parameter int WB_TGC_W  = 4,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 16
) (
  input  logic                   CLK_I,
  input  logic                   RST_I,

  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_we,
  input  logic [WB_ADDR_W-1:0]   cmd_adr,
  input  logic [WB_DATA_W-1:0]   cmd_dat,
  input  logic [WB_DATA_W/8-1:0] cmd_sel,
  input  logic                   cmd_lock,
  input  logic [WB_TGD_W-1:0]    cmd_tgd,
  input  logic [WB_TGA_W-1:0]    cmd_tga,
  input  logic [WB_TGC_W-1:0]    cmd_tgc,

  output logic                   rsp_valid,
  output logic [WB_DATA_W-1:0]   rsp_dat,
  output logic [1:0]             rsp_status,

  wishbone_master_if.master      wb
);

  wb_state_e state_q, state_d;

  // Registered command; held unchanged across every retry attempt.
  logic                   we_q;
  logic [WB_ADDR_W-1:0]   adr_q;
  logic [WB_DATA_W-1:0]   dat_q;
  logic [WB_DATA_W/8-1:0] sel_q;
  logic                   lock_q;
  logic [WB_TGD_W-1:0]    tgd_q;
  logic [WB_TGA_W-1:0]    tga_q;
  logic [WB_TGC_W-1:0]    tgc_q;

  logic [3:0]             retry_q;
  logic [7:0]             tmo_q;

  logic [WB_DATA_W-1:0]   rsp_dat_q;
  logic [1:0]             rsp_st_q;

  logic term_ack, term_err, term_rty, term_any;
  logic retry_ok, tmo_hit, cmd_fire;

  // Terminations only count while the strobe is actually out.
  assign term_ack = (state_q == BUS) && wb.ACK_I;
  assign term_err = (state_q == BUS) && wb.ERR_I;
  assign term_rty = (state_q == BUS) && wb.RTY_I;
  assign term_any = term_ack || term_err || term_rty;

  assign retry_ok = (retry_q < 4'(MAX_RETRY));
  // tmo_q counts strobe cycles already spent without termination, so the
  // attempt is abandoned on the TIMEOUT-th quiet strobe cycle.
  assign tmo_hit  = (tmo_q == 8'(TIMEOUT - 1));
  assign cmd_fire = cmd_valid && cmd_ready;

  // ---- FSM state register ----
  always_ff @(posedge CLK_I) begin
    if (RST_I) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---- FSM next state ----
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_fire) state_d = BUS;
      BUS: begin
        if (term_ack || term_err)  state_d = RESP;
        else if (term_rty)         state_d = retry_ok ? BACKOFF : RESP;
        else if (tmo_hit)          state_d = RESP;
      end
      BACKOFF: state_d = BUS;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- FSM outputs ----
  always_comb begin
    // Held low while reset is asserted even though the state already reads
    // IDLE, so no command can be accepted during reset.
    cmd_ready  = (state_q == IDLE) && !RST_I;
    rsp_valid  = (state_q == RESP);
    rsp_dat    = rsp_valid ? rsp_dat_q : '0;
    rsp_status = rsp_valid ? rsp_st_q  : WB_ST_OK;
    wb.CYC_O   = (state_q == BUS);
    wb.STB_O   = (state_q == BUS);
    wb.LOCK_O  = (state_q == BUS) && lock_q;
  end

  assign wb.ADR_O = adr_q;
  assign wb.DAT_O = dat_q;
  assign wb.SEL_O = sel_q;
  assign wb.WE_O  = we_q;
  assign wb.TGD_O = tgd_q;
  assign wb.TGA_O = tga_q;
  assign wb.TGC_O = tgc_q;

  // ---- command capture, counters and response registers ----
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      lock_q    <= 1'b0;
      tgd_q     <= '0;
      tga_q     <= '0;
      tgc_q     <= '0;
      retry_q   <= '0;
      tmo_q     <= '0;
      rsp_dat_q <= '0;
      rsp_st_q  <= WB_ST_OK;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_fire) begin
            we_q    <= cmd_we;
            adr_q   <= cmd_adr;
            dat_q   <= cmd_dat;
            sel_q   <= cmd_sel;
            lock_q  <= cmd_lock;
            tgd_q   <= cmd_tgd;
            tga_q   <= cmd_tga;
            tgc_q   <= cmd_tgc;
            retry_q <= '0;
            tmo_q   <= '0;
          end
        end
        BUS: begin
          if (!term_any)
            tmo_q <= tmo_q + 8'd1;
          if (term_rty && !term_ack && !term_err && retry_ok)
            retry_q <= retry_q + 4'd1;
          // Refreshed every strobe cycle; only the value written on the edge
          // that moves to RESP is ever presented.
          rsp_st_q  <= wb_term_status(term_ack, term_err, term_rty);
          rsp_dat_q <= (term_ack && !we_q) ? wb.DAT_I : '0;
        end
        BACKOFF: tmo_q <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_master.sv
module tb_wishbone_master;
  import wb_master_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;
  localparam int TGDW = 8;
  localparam int TGAW = 2;
  localparam int TGCW = 4;
  localparam int MAXR = 3;
  localparam int TMO  = 16;

  logic CLK_I = 1'b0;
  logic RST_I = 1'b1;
  always #5 CLK_I = ~CLK_I;

  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic            cmd_we = 1'b0;
  logic [AW-1:0]   cmd_adr = '0;
  logic [DW-1:0]   cmd_dat = '0;
  logic [SW-1:0]   cmd_sel = '0;
  logic            cmd_lock = 1'b0;
  logic [TGDW-1:0] cmd_tgd = '0;
  logic [TGAW-1:0] cmd_tga = '0;
  logic [TGCW-1:0] cmd_tgc = '0;
  logic            rsp_valid;
  logic [DW-1:0]   rsp_dat;
  logic [1:0]      rsp_status;

  wishbone_master_if #(.WB_ADDR_W(AW), .WB_DATA_W(DW), .WB_TGD_W(TGDW),
                       .WB_TGA_W(TGAW), .WB_TGC_W(TGCW)) wb ();

  wishbone_master #(.WB_ADDR_W(AW), .WB_DATA_W(DW), .WB_TGD_W(TGDW),
                    .WB_TGA_W(TGAW), .WB_TGC_W(TGCW),
                    .MAX_RETRY(MAXR), .TIMEOUT(TMO)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .cmd_lock(cmd_lock), .cmd_tgd(cmd_tgd), .cmd_tga(cmd_tga),
    .cmd_tgc(cmd_tgc), .rsp_valid(rsp_valid), .rsp_dat(rsp_dat),
    .rsp_status(rsp_status), .wb(wb)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scripted slave: per attempt, wait_a[] quiet strobe cycles and then the
  // termination set term_a[] = {ack, err, rty}; 3'b000 means never answer.
  int          wait_a [16];
  logic [2:0]  term_a [16];
  logic [DW-1:0] slv_rdata = '0;
  bit          slv_clear = 1'b1;
  int          att = 0;
  int          acnt = 0;
  bit          prev_stb = 1'b0;

  always @(negedge CLK_I) begin
    logic [2:0] t;
    t = 3'b000;
    if (slv_clear) begin
      att = 0; acnt = 0; prev_stb = 1'b0;
    end else begin
      if (!wb.STB_O && prev_stb) begin att++; acnt = 0; end
      if (wb.STB_O) begin
        if (att < 16 && acnt == wait_a[att]) t = term_a[att];
        acnt++;
      end
      prev_stb = wb.STB_O;
    end
    wb.ACK_I = t[2];
    wb.ERR_I = t[1];
    wb.RTY_I = t[0];
    wb.DAT_I = slv_rdata;
  end

  task automatic clear_script();
    for (int i = 0; i < 16; i++) begin wait_a[i] = 0; term_a[i] = 3'b000; end
  endtask

  // Reference: walk the attempts the script describes and add up strobe
  // cycles, backoff gaps and the final status.
  task automatic model(input bit we, input logic [DW-1:0] rd,
                       output logic [1:0] st, output logic [DW-1:0] d,
                       output int stb, output int gaps);
    stb = 0; gaps = 0; st = WB_ST_TMO; d = '0;
    for (int a = 0; a <= MAXR; a++) begin
      if (term_a[a] == 3'b000 || wait_a[a] >= TMO) begin
        stb += TMO; st = WB_ST_TMO; return;
      end
      stb += wait_a[a] + 1;
      if (term_a[a][2]) begin st = WB_ST_OK; d = we ? '0 : rd; return; end
      if (term_a[a][1]) begin st = WB_ST_ERR; return; end
      if (a == MAXR)    begin st = WB_ST_RTY; return; end
      gaps++;
    end
  endtask

  task automatic scramble_cmd();
    cmd_we   = 1'($urandom);
    cmd_adr  = $urandom;
    cmd_dat  = $urandom;
    cmd_sel  = SW'($urandom);
    cmd_lock = 1'($urandom);
    cmd_tgd  = TGDW'($urandom);
    cmd_tga  = TGAW'($urandom);
    cmd_tgc  = TGCW'($urandom);
  endtask

  // Returns 1 once the command has been accepted (handshake edge just passed).
  task automatic issue(input string tag, output bit hs);
    hs = 1'b0;
    slv_clear = 1'b1;
    @(posedge CLK_I); #1;
    slv_clear = 1'b0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK_I);
      if (cmd_ready) begin hs = 1'b1; break; end
    end
    if (!hs) begin
      chk({tag, ".handshake"}, 64'(0), 64'(1));
      cmd_valid = 1'b0;
      return;
    end
    @(posedge CLK_I); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_txn(input string tag);
    logic [1:0]      m_st, g_st;
    logic [DW-1:0]   m_dat, g_dat;
    int              m_stb, m_gaps, lat, stb_cnt, gaps, bad;
    bit              hs, done;
    logic            e_we, e_lock;
    logic [AW-1:0]   e_adr;
    logic [DW-1:0]   e_dat;
    logic [SW-1:0]   e_sel;
    logic [TGDW-1:0] e_tgd;
    logic [TGAW-1:0] e_tga;
    logic [TGCW-1:0] e_tgc;
    e_we = cmd_we; e_adr = cmd_adr; e_dat = cmd_dat; e_sel = cmd_sel;
    e_lock = cmd_lock; e_tgd = cmd_tgd; e_tga = cmd_tga; e_tgc = cmd_tgc;
    model(e_we, slv_rdata, m_st, m_dat, m_stb, m_gaps);
    issue(tag, hs);
    if (!hs) return;
    scramble_cmd();  // the DUT must hold its own copy from here on
    lat = 0; stb_cnt = 0; gaps = 0; bad = 0; done = 1'b0;
    g_st = '0; g_dat = '0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge CLK_I);
      if (wb.CYC_O !== wb.STB_O) bad++;
      if (wb.STB_O) begin
        stb_cnt++;
        if (wb.ADR_O !== e_adr || wb.DAT_O !== e_dat || wb.SEL_O !== e_sel ||
            wb.WE_O !== e_we || wb.LOCK_O !== e_lock || wb.TGD_O !== e_tgd ||
            wb.TGA_O !== e_tga || wb.TGC_O !== e_tgc) bad++;
      end else if (!rsp_valid) begin
        gaps++;
      end
      if (rsp_valid) begin
        lat = k; g_st = rsp_status; g_dat = rsp_dat; done = 1'b1;
        if (wb.CYC_O || wb.LOCK_O) bad++;
        break;
      end
    end
    chk({tag, ".done"},    64'(done),    64'(1));
    chk({tag, ".status"},  64'(g_st),    64'(m_st));
    chk({tag, ".rsp_dat"}, 64'(g_dat),   64'(m_dat));
    chk({tag, ".latency"}, 64'(lat),     64'(m_stb + m_gaps + 1));
    chk({tag, ".stb_cyc"}, 64'(stb_cnt), 64'(m_stb));
    chk({tag, ".gaps"},    64'(gaps),    64'(m_gaps));
    chk({tag, ".bus_out"}, 64'(bad),     64'(0));
    @(negedge CLK_I);
    chk({tag, ".ready_after"}, 64'(cmd_ready), 64'(1));
    chk({tag, ".rsp_idle"}, 64'({rsp_valid, rsp_status, rsp_dat}), 64'(0));
  endtask

  task automatic set_cmd(input bit we, input logic [AW-1:0] adr,
                         input logic [DW-1:0] dat, input logic [SW-1:0] sel);
    scramble_cmd();
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
  endtask

  initial begin
    bit hs;
    int seen;
    int r;
    clear_script();

    // Reset state
    repeat (3) @(posedge CLK_I);
    @(negedge CLK_I);
    chk("rst.cmd_ready", 64'(cmd_ready), 64'(0));
    chk("rst.bus", 64'({wb.CYC_O, wb.STB_O, wb.LOCK_O, wb.WE_O}), 64'(0));
    chk("rst.adr_dat", 64'({wb.ADR_O, wb.DAT_O}), 64'(0));
    chk("rst.rsp", 64'({rsp_valid, rsp_status, rsp_dat}), 64'(0));
    @(posedge CLK_I); #1;
    RST_I = 1'b0;
    @(negedge CLK_I);
    chk("rst.ready_after", 64'(cmd_ready), 64'(1));

    // Write, ACK one cycle after STB
    clear_script(); wait_a[0] = 1; term_a[0] = 3'b100; slv_rdata = 32'hCAFEF00D;
    set_cmd(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    run_txn("wr_ack1");

    // Read with three wait cycles
    clear_script(); wait_a[0] = 3; term_a[0] = 3'b100; slv_rdata = 32'h12345678;
    set_cmd(1'b0, 32'h204, 32'h0, 4'hF);
    run_txn("rd_wait3");

    // Combinational ACK
    clear_script(); wait_a[0] = 0; term_a[0] = 3'b100; slv_rdata = 32'hA5A5_0F0F;
    set_cmd(1'b0, 32'h300, 32'h0, 4'h3);
    run_txn("rd_comb");

    // RTY twice then ACK
    clear_script(); term_a[0] = 3'b001; term_a[1] = 3'b001; term_a[2] = 3'b100;
    wait_a[2] = 1; slv_rdata = 32'h0BAD_CAFE;
    set_cmd(1'b0, 32'h400, 32'h0, 4'hF);
    run_txn("rty2_ack");

    // RTY on every attempt
    clear_script();
    for (int i = 0; i < 16; i++) begin term_a[i] = 3'b001; wait_a[i] = 1; end
    set_cmd(1'b1, 32'h404, 32'h1111_2222, 4'hF);
    run_txn("rty_all");

    // ACK and ERR together
    clear_script(); term_a[0] = 3'b110; wait_a[0] = 1; slv_rdata = 32'h5555_AAAA;
    set_cmd(1'b0, 32'h500, 32'h0, 4'hF);
    run_txn("ack_err");

    // ERR alone on a read: data must stay 0
    clear_script(); term_a[0] = 3'b010; wait_a[0] = 2; slv_rdata = 32'h7777_8888;
    set_cmd(1'b0, 32'h504, 32'h0, 4'hF);
    run_txn("err");

    // Slave never answers
    clear_script();
    set_cmd(1'b1, 32'h600, 32'h9999_0000, 4'hC);
    run_txn("timeout");

    // Reset while the strobe is out
    clear_script();
    set_cmd(1'b1, 32'h700, 32'h1234_0000, 4'hF);
    issue("midrst", hs);
    if (hs) begin
      repeat (3) @(posedge CLK_I);
      #1 RST_I = 1'b1;
      @(negedge CLK_I);
      chk("midrst.bus_pre", 64'({wb.CYC_O, wb.STB_O}), 64'(2'b11));
      @(negedge CLK_I);
      chk("midrst.bus_drop", 64'({wb.CYC_O, wb.STB_O}), 64'(0));
      chk("midrst.ready_low", 64'(cmd_ready), 64'(0));
      @(posedge CLK_I); #1 RST_I = 1'b0;
      seen = 0;
      repeat (6) begin
        @(negedge CLK_I);
        if (rsp_valid) seen++;
      end
      chk("midrst.no_rsp", 64'(seen), 64'(0));
    end
    clear_script(); wait_a[0] = 1; term_a[0] = 3'b100; slv_rdata = 32'h0000_BEEF;
    set_cmd(1'b0, 32'h704, 32'h0, 4'hF);
    run_txn("after_rst");

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      clear_script();
      for (int a = 0; a <= MAXR; a++) begin
        r = int'($urandom_range(0, 19));
        wait_a[a] = int'($urandom_range(0, 3));
        if (r == 18) wait_a[a] = TMO - 1;
        if (r == 19) wait_a[a] = TMO;
        r = int'($urandom_range(0, 15));
        case (r)
          0, 1, 2, 3, 4:      term_a[a] = 3'b100;
          5:                  term_a[a] = 3'b110;
          6:                  term_a[a] = 3'b101;
          7, 8:               term_a[a] = 3'b010;
          9:                  term_a[a] = 3'b011;
          10, 11, 12, 13, 14: term_a[a] = 3'b001;
          default:            term_a[a] = 3'b000;
        endcase
      end
      slv_rdata = $urandom;
      scramble_cmd();
      run_txn($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wishbone_master.md
# wishbone_master

Single-cycle Wishbone classic initiator that turns a simple valid/ready command interface into Wishbone B4 classic read/write cycles. It sits between an internal requester (register sequencer, DMA control) and any Wishbone slave, and reports each completion as a one-cycle response pulse. Retry and timeout handling are built in, so a slave that answers RTY or never answers does not hang the requester.

## Interface
- WB_ADDR_W, 32, address width
- WB_DATA_W, 32, data width, multiple of 8
- WB_TGD_W, 8, data tag width
- WB_TGA_W, 2, address tag width
- WB_TGC_W, 4, cycle tag width
- MAX_RETRY, 3, re-issues allowed after RTY before giving up (0..15)
- TIMEOUT, 16, cycles STB may stay high without termination (2..255)

- CLK_I  in  1  clock; all logic on rising edge
- RST_I  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_we  in  1  1 = write, 0 = read
- cmd_adr  in  WB_ADDR_W  byte address
- cmd_dat  in  WB_DATA_W  write data
- cmd_sel  in  WB_DATA_W/8  byte enables
- cmd_lock  in  1  drive LOCK_O for this cycle
- cmd_tgd, cmd_tga, cmd_tgc  in  WB_TGD_W/WB_TGA_W/WB_TGC_W  tags, passed through
- rsp_valid  out  1  one-cycle completion pulse
- rsp_dat  out  WB_DATA_W  read data (0 for writes and non-OK completions)
- rsp_status  out  2  0 OK, 1 ERR, 2 RTY exhausted, 3 TIMEOUT
- ADR_O, DAT_O, SEL_O, WE_O, TGD_O, TGA_O, TGC_O  out  per parameters  Wishbone master outputs
- DAT_I  in  WB_DATA_W  read data from slave
- CYC_O, STB_O, LOCK_O  out  1  cycle/strobe/lock
- ACK_I, ERR_I, RTY_I  in  1  slave terminations

## Operation
- Reset: all outputs 0, state IDLE, counters 0; cmd_ready 0 during reset, 1 the cycle after.
- States: IDLE, BUS, BACKOFF, RESP.
- IDLE: cmd_ready=1. On handshake, register all cmd_* fields into ADR_O..TGC_O/LOCK_O, retry_cnt=0, tmo_cnt=0, go BUS.
- BUS: CYC_O=STB_O=1, all bus outputs held stable. Each edge samples terminations, priority ACK > ERR > RTY when several are high:
  - ACK: capture DAT_I if read; status OK; go RESP.
  - ERR: status ERR; go RESP.
  - RTY: if retry_cnt < MAX_RETRY, retry_cnt+1, go BACKOFF; else status RTY; go RESP.
  - none: tmo_cnt+1; when tmo_cnt reaches TIMEOUT-1 at an edge with no termination, status TIMEOUT, go RESP.
- BACKOFF: CYC_O=STB_O=0 for exactly one cycle; tmo_cnt=0; go BUS with the same address/data/tags.
- RESP: CYC_O=STB_O=LOCK_O=0, rsp_valid=1 for one cycle, go IDLE. rsp_dat/rsp_status valid only while rsp_valid=1, 0 otherwise.
- Terminations are ignored outside BUS.
- Reset mid-cycle: CYC_O/STB_O drop at the next edge, no rsp_valid is produced, the command is lost.

## Timing
- Handshake at edge 0 -> CYC_O/STB_O high from edge 0+ (cycle 1).
- Registered-ACK slave (ACK high cycle 2) -> STB_O low and rsp_valid high in cycle 3, cmd_ready high in cycle 4. Back-to-back throughput is one command per 4 cycles with such a slave.
- Combinational-ACK slave (ACK in cycle 1) -> rsp_valid in cycle 2.
- Each RTY adds 2 cycles (termination cycle plus BACKOFF) before STB_O reasserts.
- TIMEOUT=16 -> STB_O high for exactly 16 cycles, then rsp_valid with status 3.

## Structure
- Package wb_master_pkg: state enum (IDLE/BUS/BACKOFF/RESP) and status constants (WB_ST_OK=0, WB_ST_ERR=1, WB_ST_RTY=2, WB_ST_TMO=3).
- Single module, no sub-modules; counters and FSM are inline.

## Test plan
- Write 0xDEADBEEF to 0x100, sel 0xF, slave ACKs in the cycle after STB -> WE_O=1 and DAT_O stable while STB_O is high; rsp_valid in cycle 3, status 0, rsp_dat 0.
- Read 0x204, slave returns 0x12345678 with ACK after 3 wait cycles -> rsp_dat 0x12345678, status 0, STB_O high for 4 cycles.
- Slave asserts RTY twice then ACK (MAX_RETRY=3) -> two one-cycle CYC_O gaps, status 0. With RTY on every attempt -> 4 attempts, then status 2.
- Slave asserts ACK and ERR in the same cycle -> status 0 (ACK wins). ERR alone -> status 1, rsp_dat 0.
- Slave never terminates, TIMEOUT=16 -> STB_O high for exactly 16 cycles, status 3, cmd_ready returns.
- RST_I pulsed while in BUS -> CYC_O/STB_O 0 at the next edge, no rsp_valid, and the next command completes normally.
